// File: rtl/sell_ctrl.sv
// sell_ctrl: customer-side vending transaction controller.
// Sequences aisle select, quantity entry and payment, and keeps the stock and sales counters.
module sell_ctrl #(
    parameter logic [4:0]  PRICE1      = 5'd4,
    parameter logic [4:0]  PRICE2      = 5'd9,
    parameter logic [4:0]  PRICE3      = 5'd13,
    parameter logic [4:0]  PRICE4      = 5'd17,
    parameter logic [7:0]  MAX_STOCK   = 8'd99,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sel,
    input  logic       key_vld,
    input  logic [3:0] key_value,
    input  logic       coin_vld,
    input  logic [4:0] coin_val,
    input  logic       confirm,
    input  logic       cancel,
    input  logic       stk_load,
    input  logic [7:0] in_S1_num,
    input  logic [7:0] in_S2_num,
    input  logic [7:0] in_S3_num,
    input  logic [7:0] in_S4_num,
    output logic [7:0] S1_num,
    output logic [7:0] S2_num,
    output logic [7:0] S3_num,
    output logic [7:0] S4_num,
    output logic [7:0] S1_sell,
    output logic [7:0] S2_sell,
    output logic [7:0] S3_sell,
    output logic [7:0] S4_sell,
    output logic [7:0] price_sum,
    output logic [7:0] change,
    output logic       dispense,
    output logic       err,
    output logic [2:0] state
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PAY    = 3'd2,
        ST_DONE   = 3'd3,
        ST_REFUND = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'd255 : s[7:0];
    endfunction

    function automatic logic [4:0] price_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return PRICE1;
            2'd1:    return PRICE2;
            2'd2:    return PRICE3;
            2'd3:    return PRICE4;
            default: return PRICE1;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  aisle_r;
    logic [3:0]  qty_r;
    logic [7:0]  due_r, paid_r, change_r, price_sum_r;
    logic [7:0]  num_r [4];
    logic [7:0]  sell_r [4];
    logic [7:0]  in_num_s [4];
    logic [TW-1:0] tmo_r;
    logic        dispense_r, err_r;

    logic [1:0]  sel_idx_s;
    logic        sel_vld_s, key_ok_s, act_s, tmo_hit_s;
    logic        sel_take_s, qty_take_s, sale_take_s, refund_take_s, timing_s;
    logic [7:0]  paid_nxt_s, stock_sel_s, due_calc_s;

    assign in_num_s[0] = in_S1_num;
    assign in_num_s[1] = in_S2_num;
    assign in_num_s[2] = in_S3_num;
    assign in_num_s[3] = in_S4_num;

    assign key_ok_s    = key_vld && (key_value != 4'd0) && (key_value <= 4'd9);
    assign act_s       = key_vld || coin_vld || confirm;
    assign timing_s    = (state_r == ST_SELECT) || (state_r == ST_PAY);
    assign tmo_hit_s   = timing_s && !act_s && (tmo_r == TMO_LAST);
    assign stock_sel_s = num_r[aisle_r];
    assign due_calc_s  = {3'd0, price_of(aisle_r)} * {4'd0, key_value};
    assign paid_nxt_s  = coin_vld ? sat_add8(paid_r, {3'd0, coin_val}) : paid_r;

    assign sel_take_s    = (state_r == ST_IDLE) && sel_vld_s;
    assign qty_take_s    = (state_r == ST_SELECT) && (state_nxt_s == ST_PAY);
    assign sale_take_s   = (state_nxt_s == ST_DONE);
    assign refund_take_s = (state_nxt_s == ST_REFUND);

    // One-hot aisle decode; anything else is not a valid selection
    always_comb begin
        sel_idx_s = 2'd0;
        sel_vld_s = 1'b0;
        case (sel)
            4'b0001: begin sel_idx_s = 2'd0; sel_vld_s = 1'b1; end
            4'b0010: begin sel_idx_s = 2'd1; sel_vld_s = 1'b1; end
            4'b0100: begin sel_idx_s = 2'd2; sel_vld_s = 1'b1; end
            4'b1000: begin sel_idx_s = 2'd3; sel_vld_s = 1'b1; end
            default: begin sel_idx_s = 2'd0; sel_vld_s = 1'b0; end
        endcase
    end

    // Next-state logic; cancel outranks every other input
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_vld_s) state_nxt_s = ST_SELECT;
                else           state_nxt_s = ST_IDLE;
            end
            ST_SELECT: begin
                if (cancel)                                 state_nxt_s = ST_REFUND;
                else if (key_ok_s && ({4'd0, key_value} > stock_sel_s)) state_nxt_s = ST_ERR;
                else if (key_ok_s)                          state_nxt_s = ST_PAY;
                else if (tmo_hit_s)                         state_nxt_s = ST_REFUND;
                else                                        state_nxt_s = ST_SELECT;
            end
            ST_PAY: begin
                if (cancel)                                 state_nxt_s = ST_REFUND;
                else if (confirm && (paid_nxt_s >= due_r))  state_nxt_s = ST_DONE;
                else if (tmo_hit_s)                         state_nxt_s = ST_REFUND;
                else                                        state_nxt_s = ST_PAY;
            end
            ST_DONE:   state_nxt_s = ST_IDLE;
            ST_REFUND: state_nxt_s = ST_IDLE;
            ST_ERR: begin
                if (cancel) state_nxt_s = ST_REFUND;
                else        state_nxt_s = ST_ERR;
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_nxt_s;
    end

    // Transaction datapath and counters; DONE/REFUND effects land on entry so they show during that state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aisle_r     <= 2'd0;
            qty_r       <= 4'd0;
            due_r       <= 8'd0;
            paid_r      <= 8'd0;
            change_r    <= 8'd0;
            price_sum_r <= 8'd0;
            tmo_r       <= '0;
            dispense_r  <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                num_r[i]  <= 8'd0;
                sell_r[i] <= 8'd0;
            end
        end else begin
            dispense_r <= sale_take_s;
            err_r      <= (state_nxt_s == ST_ERR);
            if ((state_r == ST_IDLE) && stk_load) begin
                for (int i = 0; i < 4; i++) begin
                    num_r[i] <= (in_num_s[i] > MAX_STOCK) ? MAX_STOCK : in_num_s[i];
                end
            end
            if (sel_take_s) begin
                aisle_r  <= sel_idx_s;
                paid_r   <= 8'd0;
                change_r <= 8'd0;
            end
            if (qty_take_s) begin
                qty_r <= key_value;
                due_r <= due_calc_s;
            end
            if ((state_r == ST_PAY) && !refund_take_s) begin
                paid_r <= paid_nxt_s;
            end
            if (refund_take_s) begin
                change_r <= paid_r;
                paid_r   <= 8'd0;
            end
            if (sale_take_s) begin
                change_r        <= paid_nxt_s - due_r;
                num_r[aisle_r]  <= num_r[aisle_r] - {4'd0, qty_r};
                sell_r[aisle_r] <= sat_add8(sell_r[aisle_r], {4'd0, qty_r});
                price_sum_r     <= sat_add8(price_sum_r, due_r);
            end
            if (timing_s && !act_s && !tmo_hit_s) tmo_r <= tmo_r + TMO_ONE;
            else                                  tmo_r <= '0;
        end
    end

    assign S1_num    = num_r[0];
    assign S2_num    = num_r[1];
    assign S3_num    = num_r[2];
    assign S4_num    = num_r[3];
    assign S1_sell   = sell_r[0];
    assign S2_sell   = sell_r[1];
    assign S3_sell   = sell_r[2];
    assign S4_sell   = sell_r[3];
    assign price_sum = price_sum_r;
    assign change    = change_r;
    assign dispense  = dispense_r;
    assign err       = err_r;
    assign state     = state_r;
endmodule
